// File: rtl/eic_prio_ctrl_pkg.sv
// Shared definitions for the external interrupt controller: bus sizing,
// register offsets, access-size codes and FSM state encoding.
package eic_prio_ctrl_pkg;

    localparam int BUS_WIDTH   = 32;
    localparam int BUS_ACC_CNT = 3;
    localparam int ACC_W       = $clog2(BUS_ACC_CNT);

    localparam int ACC_BYTE = 0;
    localparam int ACC_HALF = 1;
    localparam int ACC_WORD = 2;

    localparam int EIC_SIZE    = 32;
    localparam int EIC_PENDING = 'h00;
    localparam int EIC_ENABLE  = 'h04;
    localparam int EIC_MODE    = 'h08;
    localparam int EIC_CLAIM   = 'h0C;
    localparam int EIC_STATUS  = 'h10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_SERVICE = 2'd2
    } eic_state_e;

endpackage

// File: rtl/eic_src_sync.sv
// One interrupt source: synchroniser chain, edge detector and the pending bit
// with edge (set on rise, cleared by W1C or claim) or level behaviour.
module eic_src_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic src,
    input  logic mode,
    input  logic w1c,
    input  logic claim_clr,
    output logic pending
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;
    logic                   pend_q, pend_d;
    logic                   synced, rise;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], src};
        synced = sync_q[SYNC_STAGES-1];
        dly_d  = synced;
        rise   = synced & ~dly_q;
        pend_d = pend_q;
        // A fresh edge outranks any clear arriving in the same cycle.
        if (mode) begin
            pend_d = synced;
        end else if (rise) begin
            pend_d = 1'b1;
        end else if (w1c || claim_clr) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
            pend_q <= pend_d;
        end
    end

    assign pending = pend_q;

endmodule

// File: rtl/eic_prio_ctrl.sv
// External interrupt controller: per-source pending/enable/mode registers,
// fixed lowest-index-wins arbitration and a claim/complete handshake FSM.
module eic_prio_ctrl
    import eic_prio_ctrl_pkg::*;
#(
    parameter int NSRC        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AW          = 5
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [AW-1:0]        p_addr,
    input  logic                 p_w_rb,
    input  logic [ACC_W-1:0]     p_acc,
    input  logic [BUS_WIDTH-1:0] p_wdata,
    output logic [BUS_WIDTH-1:0] p_rdata,
    input  logic                 p_req,
    output logic                 p_resp,
    output logic                 eic_fault,
    output logic                 ext_int_trigger,
    input  logic                 ext_int_handled,
    input  logic [NSRC-1:0]      ext_int_src
);

    logic [NSRC-1:0]      pending, req, w1c, claim_clr;
    logic [NSRC-1:0]      enable_q, enable_d, mode_q, mode_d;
    eic_state_e           state_q, state_d;
    logic [4:0]           id_q, id_d, req_id;
    logic                 trig_q, trig_d;
    logic                 resp_q, resp_d, fault_q, fault_d;
    logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
    logic                 acc_fault, rd_ok, wr_ok, claim_hit;
    logic                 unused_wdata;

    assign unused_wdata = ^p_wdata;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        eic_src_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_src (
            .clk      (clk),
            .rstn     (rstn),
            .src      (ext_int_src[i]),
            .mode     (mode_q[i]),
            .w1c      (w1c[i]),
            .claim_clr(claim_clr[i]),
            .pending  (pending[i])
        );
    end

    always_comb begin
        acc_fault = (p_acc != ACC_W'(ACC_WORD))
                 || (p_addr[1:0] != 2'b00)
                 || (p_addr > AW'(EIC_STATUS))
                 || (p_w_rb && (p_addr == AW'(EIC_CLAIM) || p_addr == AW'(EIC_STATUS)));
        rd_ok     = p_req && !acc_fault && !p_w_rb;
        wr_ok     = p_req && !acc_fault && p_w_rb;
        claim_hit = rd_ok && (p_addr == AW'(EIC_CLAIM)) && (state_q == ST_ACTIVE);

        w1c = (wr_ok && p_addr == AW'(EIC_PENDING)) ? p_wdata[NSRC-1:0] : '0;
        for (int i = 0; i < NSRC; i++) begin
            claim_clr[i] = claim_hit && (id_q == 5'(i));
        end

        enable_d = (wr_ok && p_addr == AW'(EIC_ENABLE)) ? p_wdata[NSRC-1:0] : enable_q;
        mode_d   = (wr_ok && p_addr == AW'(EIC_MODE))   ? p_wdata[NSRC-1:0] : mode_q;

        rdata_d = '0;
        if (rd_ok) begin
            case (p_addr)
                AW'(EIC_PENDING): rdata_d[NSRC-1:0] = pending;
                AW'(EIC_ENABLE):  rdata_d[NSRC-1:0] = enable_q;
                AW'(EIC_MODE):    rdata_d[NSRC-1:0] = mode_q;
                AW'(EIC_CLAIM): begin
                    if (state_q == ST_ACTIVE) begin
                        rdata_d[31]  = 1'b1;
                        rdata_d[4:0] = id_q;
                    end
                end
                AW'(EIC_STATUS): begin
                    rdata_d[12:8] = id_q;
                    rdata_d[1:0]  = state_q;
                end
                default: rdata_d = '0;
            endcase
        end
        resp_d  = p_req;
        fault_d = p_req && acc_fault;
    end

    always_comb begin
        req    = pending & enable_q;
        req_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                req_id = 5'(i);
            end
        end

        state_d = state_q;
        id_d    = id_q;
        // The id is latched on entry to ACTIVE and held until the handshake ends.
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_ACTIVE;
                    id_d    = req_id;
                end
            end
            ST_ACTIVE: begin
                if (claim_hit) begin
                    state_d = ST_SERVICE;
                end else if (ext_int_handled) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (ext_int_handled) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        trig_d = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            id_q     <= '0;
            trig_q   <= 1'b0;
            enable_q <= '0;
            mode_q   <= '0;
            resp_q   <= 1'b0;
            fault_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            trig_q   <= trig_d;
            enable_q <= enable_d;
            mode_q   <= mode_d;
            resp_q   <= resp_d;
            fault_q  <= fault_d;
            rdata_q  <= rdata_d;
        end
    end

    assign p_rdata         = rdata_q;
    assign p_resp          = resp_q;
    assign eic_fault       = fault_q;
    assign ext_int_trigger = trig_q;

endmodule

// File: tb/tb_eic_prio_ctrl.sv
// Bench for eic_prio_ctrl: directed scenarios plus a randomized run, with every
// output compared each cycle against a behavioural model of the controller.
module tb_eic_prio_ctrl;

    localparam int NSRC = 8;
    localparam int SS   = 2;

    logic        clk;
    logic        rstn;
    logic [4:0]  p_addr;
    logic        p_w_rb;
    logic [1:0]  p_acc;
    logic [31:0] p_wdata;
    logic [31:0] p_rdata;
    logic        p_req;
    logic        p_resp;
    logic        eic_fault;
    logic        ext_int_trigger;
    logic        ext_int_handled;
    logic [NSRC-1:0] ext_int_src;

    eic_prio_ctrl #(.NSRC(NSRC), .SYNC_STAGES(SS), .AW(5)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .p_addr         (p_addr),
        .p_w_rb         (p_w_rb),
        .p_acc          (p_acc),
        .p_wdata        (p_wdata),
        .p_rdata        (p_rdata),
        .p_req          (p_req),
        .p_resp         (p_resp),
        .eic_fault      (eic_fault),
        .ext_int_trigger(ext_int_trigger),
        .ext_int_handled(ext_int_handled),
        .ext_int_src    (ext_int_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model state
    logic [NSRC-1:0] m_pend, m_en, m_mode;
    logic [NSRC-1:0] m_hist [SS+1];
    int              m_state;
    int              m_id;
    logic            m_resp, m_fault;
    logic [31:0]     m_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [NSRC-1:0] syn, prv, nxt;
        logic flt, rdok, wrok, claim;
        logic [31:0] rd;
        if (!rstn) begin
            m_pend = '0; m_en = '0; m_mode = '0;
            m_state = 0; m_id = 0;
            m_resp = 0; m_fault = 0; m_rdata = '0;
            for (int k = 0; k <= SS; k++) m_hist[k] = '0;
            return;
        end
        syn  = m_hist[SS-1];
        prv  = m_hist[SS];
        flt  = (p_acc != 2) || (p_addr[1:0] != 0) || (p_addr > 16)
            || (p_w_rb && (p_addr == 12 || p_addr == 16));
        rdok = p_req && !flt && !p_w_rb;
        wrok = p_req && !flt && p_w_rb;
        claim = rdok && p_addr == 12 && m_state == 1;
        rd = 0;
        if (rdok) begin
            case (p_addr)
                0:  rd = 32'(m_pend);
                4:  rd = 32'(m_en);
                8:  rd = 32'(m_mode);
                12: rd = (m_state == 1) ? (32'h8000_0000 | 32'(m_id)) : 32'h0;
                16: rd = (32'(m_id) << 8) | 32'(m_state);
                default: rd = 0;
            endcase
        end
        for (int i = 0; i < NSRC; i++) begin
            if (m_mode[i])                   nxt[i] = syn[i];
            else if (syn[i] && !prv[i])      nxt[i] = 1'b1;
            else if ((wrok && p_addr == 0 && p_wdata[i]) || (claim && m_id == i)) nxt[i] = 1'b0;
            else                             nxt[i] = m_pend[i];
        end
        case (m_state)
            0: if ((m_pend & m_en) != 0) begin
                   for (int i = 0; i < NSRC; i++) begin
                       if (m_pend[i] && m_en[i]) begin
                           m_id = i;
                           break;
                       end
                   end
                   m_state = 1;
               end
            1: if (claim) m_state = 2; else if (ext_int_handled) m_state = 0;
            default: if (ext_int_handled) m_state = 0;
        endcase
        if (wrok && p_addr == 4) m_en   = p_wdata[NSRC-1:0];
        if (wrok && p_addr == 8) m_mode = p_wdata[NSRC-1:0];
        m_pend = nxt;
        for (int k = SS; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = ext_int_src;
        m_resp  = p_req;
        m_fault = p_req && flt;
        m_rdata = rd;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("p_resp",  32'(p_resp), 32'(m_resp));
        chk("p_rdata", p_rdata, m_rdata);
        chk("eic_fault", 32'(eic_fault), 32'(m_fault));
        chk("trigger", 32'(ext_int_trigger), 32'(m_state == 1));
    endtask

    task automatic bus(input logic w, input logic [4:0] a, input logic [1:0] acc,
                       input logic [31:0] d, output logic [31:0] rd,
                       output logic flt, output logic rsp);
        p_req = 1'b1; p_w_rb = w; p_addr = a; p_acc = acc; p_wdata = d;
        cyc();
        rd = p_rdata; flt = eic_fault; rsp = p_resp;
        p_req = 1'b0; p_w_rb = 1'b0; p_addr = '0; p_acc = 2'd2; p_wdata = '0;
    endtask

    task automatic rd32(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] rd; logic flt, rsp;
        bus(1'b0, a, 2'd2, 32'h0, rd, flt, rsp);
        chk(tag, rd, exp);
        chk({tag, "_resp"}, 32'(rsp), 32'd1);
    endtask

    task automatic wr32(input logic [4:0] a, input logic [31:0] d);
        logic [31:0] rd; logic flt, rsp;
        bus(1'b1, a, 2'd2, d, rd, flt, rsp);
    endtask

    task automatic fault_acc(input string tag, input logic w, input logic [4:0] a, input logic [1:0] acc);
        logic [31:0] rd; logic flt, rsp;
        bus(w, a, acc, 32'hFFFF_FFFF, rd, flt, rsp);
        chk({tag, "_fault"}, 32'(flt), 32'd1);
        chk({tag, "_resp"}, 32'(rsp), 32'd1);
        chk({tag, "_rdata"}, rd, 32'd0);
    endtask

    task automatic handled();
        ext_int_handled = 1'b1;
        cyc();
        ext_int_handled = 1'b0;
    endtask

    task automatic wait_trig(input string tag, input logic lvl, input int max);
        for (int n = 0; n < max; n++) begin
            if (ext_int_trigger === lvl) break;
            cyc();
        end
        chk(tag, 32'(ext_int_trigger), 32'(lvl));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    initial begin
        rstn = 1'b0; p_addr = '0; p_w_rb = 1'b0; p_acc = 2'd2; p_wdata = '0;
        p_req = 1'b0; ext_int_handled = 1'b0; ext_int_src = '0;
        idle(2);
        chk("rst_trigger", 32'(ext_int_trigger), 32'd0);
        chk("rst_resp", 32'(p_resp), 32'd0);
        rstn = 1'b1;
        cyc();
        rd32("rst_pending", 5'h00, 32'h0);
        rd32("rst_enable",  5'h04, 32'h0);
        rd32("rst_mode",    5'h08, 32'h0);
        rd32("rst_status",  5'h10, 32'h0);
        cyc();
        chk("resp_one_cycle", 32'(p_resp), 32'd0);

        // Edge path: latch both edges first, then enable them together.
        ext_int_src[3] = 1'b1; idle(2); ext_int_src[3] = 1'b0;
        ext_int_src[2] = 1'b1; idle(2); ext_int_src[2] = 1'b0;
        idle(SS + 2);
        rd32("edge_pending_both", 5'h00, 32'h0C);
        wr32(5'h04, 32'h0C);
        wait_trig("edge_trig_rise", 1'b1, SS + 3);
        rd32("edge_claim2", 5'h0C, 32'h8000_0002);
        chk("edge_trig_fall", 32'(ext_int_trigger), 32'd0);
        rd32("edge_pending8", 5'h00, 32'h08);
        rd32("edge_status_svc", 5'h10, 32'h0000_0202);
        handled();
        wait_trig("edge_retrig", 1'b1, 4);
        rd32("edge_claim3", 5'h0C, 32'h8000_0003);
        handled();
        rd32("edge_pending0", 5'h00, 32'h0);

        // Level path
        wr32(5'h08, 32'h20);
        wr32(5'h04, 32'h20);
        ext_int_src[5] = 1'b1;
        wait_trig("lvl_trig", 1'b1, SS + 4);
        rd32("lvl_claim5", 5'h0C, 32'h8000_0005);
        rd32("lvl_pending_held", 5'h00, 32'h20);
        handled();
        wait_trig("lvl_retrig", 1'b1, 4);
        ext_int_src[5] = 1'b0;
        idle(SS + 3);
        rd32("lvl_pending_drop", 5'h00, 32'h0);
        chk("lvl_trig_held", 32'(ext_int_trigger), 32'd1);
        handled();
        cyc();
        rd32("claim_idle_a", 5'h0C, 32'h0);

        // Faults
        fault_acc("byte_rd_04", 1'b0, 5'h04, 2'd0);
        fault_acc("misalign_06", 1'b0, 5'h06, 2'd2);
        fault_acc("oob_14", 1'b0, 5'h14, 2'd2);
        fault_acc("wr_claim", 1'b1, 5'h0C, 2'd2);
        rd32("fault_enable_kept", 5'h04, 32'h20);
        rd32("fault_mode_kept",   5'h08, 32'h20);

        // Edge set collides with W1C on the same bit
        wr32(5'h08, 32'h0);
        wr32(5'h04, 32'h0);
        ext_int_src[1] = 1'b1;
        idle(2);
        wr32(5'h00, 32'h02);
        rd32("set_beats_w1c", 5'h00, 32'h02);
        rd32("claim_idle_b", 5'h0C, 32'h0);
        wr32(5'h00, 32'h02);
        rd32("w1c_clears", 5'h00, 32'h0);

        // Reset while ACTIVE with a request outstanding
        ext_int_src[1] = 1'b0; idle(SS + 2);
        ext_int_src[1] = 1'b1; idle(SS + 2);
        wr32(5'h04, 32'h02);
        wait_trig("pre_rst_trig", 1'b1, 4);
        ext_int_src[1] = 1'b0;
        p_req = 1'b1; p_w_rb = 1'b0; p_addr = 5'h04; p_acc = 2'd2;
        rstn = 1'b0;
        cyc();
        p_req = 1'b0; p_addr = '0;
        chk("midrst_trigger", 32'(ext_int_trigger), 32'd0);
        rstn = 1'b1;
        cyc();
        chk("midrst_no_resp", 32'(p_resp), 32'd0);
        rd32("midrst_enable",  5'h04, 32'h0);
        rd32("midrst_pending", 5'h00, 32'h0);
        rd32("midrst_mode",    5'h08, 32'h0);

        // Randomized traffic against the model
        for (int it = 0; it < 1500; it++) begin
            int sel;
            rstn = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 5) == 0) begin
                sel = $urandom_range(0, NSRC - 1);
                ext_int_src[sel] = ~ext_int_src[sel];
            end
            ext_int_handled = ($urandom_range(0, 9) == 0);
            p_req = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 5);
            case (sel)
                0: p_addr = 5'h00;
                1: p_addr = 5'h04;
                2: p_addr = 5'h08;
                3: p_addr = 5'h0C;
                4: p_addr = 5'h10;
                default: p_addr = 5'($urandom_range(0, 31));
            endcase
            p_acc   = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
            p_w_rb  = ($urandom_range(0, 3) == 0);
            p_wdata = $urandom;
            cyc();
        end
        rstn = 1'b1; p_req = 1'b0; ext_int_handled = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
